// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared state encoding, default polynomials and helpers for the multi-chain BIST
package bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CAPTURE,
    ST_UNLOAD,
    ST_COMPARE,
    ST_DONE
  } bist_state_e;

  localparam logic [15:0] DEF_LFSR_TAPS = 16'hB400;
  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;
  localparam logic [15:0] DEF_MISR_TAPS = 16'hB400;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

endpackage

// File: rtl/bist_controller_mc_if.sv
// rtl/bist_controller_mc_if.sv - bistmode pin and CUT scan port bundle
interface bist_controller_mc_if #(
  parameter int NUM_CHAINS = 4,
  parameter int MISR_W     = 16
);
  logic                  bistmode;
  logic [NUM_CHAINS-1:0] cut_sdo;
  logic                  cut_scanmode;
  logic [NUM_CHAINS-1:0] cut_sdi;
  logic                  bistdone;
  logic                  bistpass;
  logic [MISR_W-1:0]     signature;
  logic [15:0]           pattern_idx;

  modport master (
    output bistmode, cut_sdo,
    input  cut_scanmode, cut_sdi, bistdone, bistpass, signature, pattern_idx
  );

  modport slave (
    input  bistmode, cut_sdo,
    output cut_scanmode, cut_sdi, bistdone, bistpass, signature, pattern_idx
  );
endinterface

// File: rtl/bist_controller_mc_lfsr_gen.sv
// rtl/bist_controller_mc_lfsr_gen.sv - Galois right-shift pattern LFSR with seed load
module lfsr_gen #(
  parameter int             W     = 16,
  parameter int             OUT_W = 4,
  parameter logic [W-1:0]   TAPS  = 16'hB400,
  parameter logic [W-1:0]   SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  output logic [OUT_W-1:0] lfsr_o
);
  logic [W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (en_i) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q[OUT_W-1:0];
endmodule

// File: rtl/bist_controller_mc_misr_mi.sv
// rtl/bist_controller_mc_misr_mi.sv - multi-input signature register compacting all chain outputs
module misr_mi #(
  parameter int           W    = 16,
  parameter int           N    = 4,
  parameter logic [W-1:0] TAPS = 16'hB400
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [N-1:0] data_i,
  output logic [W-1:0] sig_o
);
  logic [W-1:0] misr_q, misr_d, data_ext;

  always_comb begin
    data_ext         = '0;
    data_ext[N-1:0]  = data_i;
    misr_d           = misr_q;
    if (clr_i) begin
      misr_d = '0;
    end else if (en_i) begin
      misr_d = {misr_q[W-2:0], 1'b0} ^ (misr_q[W-1] ? TAPS : '0) ^ data_ext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misr_q <= '0;
    end else begin
      misr_q <= misr_d;
    end
  end

  assign sig_o = misr_q;
endmodule

// File: rtl/bist_controller_mc.sv
// rtl/bist_controller_mc.sv - multi-chain BIST sequencer: shift/capture/unload FSM, counters and golden compare
module bist_controller_mc
  import bist_pkg::*;
#(
  parameter int                NUM_CHAINS   = 4,
  parameter int                CHAIN_LEN    = 57,
  parameter int                NUM_PATTERNS = 2000,
  parameter int                LFSR_W       = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS    = DEF_LFSR_TAPS,
  parameter logic [LFSR_W-1:0] LFSR_SEED    = DEF_LFSR_SEED,
  parameter int                MISR_W       = 16,
  parameter logic [MISR_W-1:0] MISR_TAPS    = DEF_MISR_TAPS,
  parameter logic [MISR_W-1:0] GOLDEN_SIG   = '0,
  parameter bit                LEARN_GOLDEN = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  bist_controller_mc_if.slave bus
);
  localparam int                CNT_W    = clog2(CHAIN_LEN);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [15:0]       NP16     = 16'(NUM_PATTERNS);

  if (NUM_CHAINS < 1 || NUM_CHAINS > LFSR_W) begin : g_bad_lfsr_w
    $error("NUM_CHAINS must be 1..LFSR_W");
  end
  if (NUM_CHAINS > MISR_W) begin : g_bad_misr_w
    $error("NUM_CHAINS must not exceed MISR_W");
  end
  if (LFSR_SEED == '0) begin : g_bad_seed
    $error("LFSR_SEED must be non-zero");
  end
  if (NUM_PATTERNS < 1 || NUM_PATTERNS > 65535) begin : g_bad_np
    $error("NUM_PATTERNS must be 1..65535");
  end
  if (CHAIN_LEN < 2) begin : g_bad_len
    $error("CHAIN_LEN must be at least 2");
  end

  bist_state_e           state_q, state_d;
  logic [CNT_W-1:0]      shift_cnt_q, shift_cnt_d;
  logic [15:0]           pidx_q, pidx_d, pidx_inc;
  logic [MISR_W-1:0]     golden_q, golden_d;
  logic                  learned_q, learned_d;
  logic                  pass_q, pass_d;

  logic                  lfsr_en, lfsr_load, misr_en, misr_clr, scanmode;
  logic [NUM_CHAINS-1:0] sdi, lfsr_bits;
  logic [MISR_W-1:0]     misr;

  lfsr_gen #(
    .W(LFSR_W), .OUT_W(NUM_CHAINS), .TAPS(LFSR_TAPS), .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk(clk), .rst(rst), .en_i(lfsr_en), .load_i(lfsr_load), .lfsr_o(lfsr_bits)
  );

  misr_mi #(
    .W(MISR_W), .N(NUM_CHAINS), .TAPS(MISR_TAPS)
  ) u_misr (
    .clk(clk), .rst(rst), .en_i(misr_en), .clr_i(misr_clr),
    .data_i(bus.cut_sdo), .sig_o(misr)
  );

  assign pidx_inc = (pidx_q == 16'hFFFF) ? pidx_q : pidx_q + 16'd1;

  // Every active state drops straight to IDLE with no stepping when bistmode falls.
  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    pidx_d      = pidx_q;
    golden_d    = golden_q;
    learned_d   = learned_q;
    pass_d      = pass_q;
    lfsr_en     = 1'b0;
    lfsr_load   = 1'b0;
    misr_en     = 1'b0;
    misr_clr    = 1'b0;
    scanmode    = 1'b0;
    sdi         = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.bistmode) begin
          state_d     = ST_SHIFT;
          shift_cnt_d = '0;
          pidx_d      = '0;
          lfsr_load   = 1'b1;
          misr_clr    = 1'b1;
        end
      end
      ST_SHIFT: begin
        scanmode = 1'b1;
        sdi      = lfsr_bits;
        if (!bus.bistmode) begin
          state_d = ST_IDLE;
        end else begin
          lfsr_en = 1'b1;
          // Chains hold unknown data until the first pattern has been captured.
          misr_en = (pidx_q != 16'd0);
          if (shift_cnt_q == CNT_LAST) begin
            shift_cnt_d = '0;
            state_d     = ST_CAPTURE;
          end else begin
            shift_cnt_d = shift_cnt_q + 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        if (!bus.bistmode) begin
          state_d = ST_IDLE;
        end else begin
          pidx_d  = pidx_inc;
          state_d = (pidx_inc < NP16) ? ST_SHIFT : ST_UNLOAD;
        end
      end
      ST_UNLOAD: begin
        scanmode = 1'b1;
        if (!bus.bistmode) begin
          state_d = ST_IDLE;
        end else begin
          misr_en = 1'b1;
          if (shift_cnt_q == CNT_LAST) begin
            shift_cnt_d = '0;
            state_d     = ST_COMPARE;
          end else begin
            shift_cnt_d = shift_cnt_q + 1'b1;
          end
        end
      end
      ST_COMPARE: begin
        if (!bus.bistmode) begin
          state_d = ST_IDLE;
        end else begin
          if (LEARN_GOLDEN && !learned_q) begin
            golden_d  = misr;
            learned_d = 1'b1;
            pass_d    = 1'b1;
          end else begin
            pass_d = (misr == golden_q);
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!bus.bistmode) begin
          state_d = ST_IDLE;
          pass_d  = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      shift_cnt_q <= '0;
      pidx_q      <= '0;
      golden_q    <= GOLDEN_SIG;
      learned_q   <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      pidx_q      <= pidx_d;
      golden_q    <= golden_d;
      learned_q   <= learned_d;
      pass_q      <= pass_d;
    end
  end

  assign bus.cut_scanmode = scanmode;
  assign bus.cut_sdi      = sdi;
  assign bus.bistdone     = (state_q == ST_DONE);
  assign bus.bistpass     = (state_q == ST_DONE) && pass_q;
  assign bus.signature    = misr;
  assign bus.pattern_idx  = pidx_q;
endmodule

// File: tb/tb_bist_controller_mc.sv
// tb/tb_bist_controller_mc.sv - bench for bist_controller_mc with loopback and stuck-at CUT models
module tb_bist_controller_mc;
  localparam int          NC   = 2;
  localparam int          L    = 4;
  localparam int          NP   = 3;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  typedef struct {
    logic [15:0] sig;
    logic        done;
    logic        pass;
    logic [15:0] pidx;
  } exp_t;

  typedef struct {
    int edge_n;
    bit scan;
    bit done;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  bit   bistmode;
  int   checks;
  int   errors;

  always #5 clk = ~clk;

  bist_controller_mc_if #(.NUM_CHAINS(NC), .MISR_W(16)) bus_l ();
  bist_controller_mc_if #(.NUM_CHAINS(NC), .MISR_W(16)) bus_f ();

  bist_controller_mc #(
    .NUM_CHAINS(NC), .CHAIN_LEN(L), .NUM_PATTERNS(NP), .LEARN_GOLDEN(1'b1)
  ) dut_l (.clk(clk), .rst(rst), .bus(bus_l));

  bist_controller_mc #(
    .NUM_CHAINS(NC), .CHAIN_LEN(L), .NUM_PATTERNS(NP), .GOLDEN_SIG(16'h0000), .LEARN_GOLDEN(1'b0)
  ) dut_f (.clk(clk), .rst(rst), .bus(bus_f));

  // Scan chains that only shift; chain 1 flop 2 of the second CUT is stuck at 1.
  bit   [L-1:0] chain_l [NC];
  bit   [L-1:0] chain_f [NC];
  logic [L-1:0] eff_f   [NC];
  logic [NC-1:0] sdo_l, sdo_f;

  always_comb begin
    eff_f[0] = chain_f[0];
    eff_f[1] = chain_f[1] | 4'b0100;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NC; i++) begin
      if (bus_l.cut_scanmode) chain_l[i] <= {chain_l[i][L-2:0], bus_l.cut_sdi[i]};
      if (bus_f.cut_scanmode) chain_f[i] <= {eff_f[i][L-2:0], bus_f.cut_sdi[i]};
    end
  end

  assign sdo_l = {chain_l[1][L-1], chain_l[0][L-1]};
  assign sdo_f = {eff_f[1][L-1], eff_f[0][L-1]};
  assign bus_l.bistmode = bistmode;
  assign bus_f.bistmode = bistmode;
  assign bus_l.cut_sdo  = sdo_l;
  assign bus_f.cut_sdo  = sdo_f;

  bit          m_run, m_done, m_pass, m_learned;
  int          m_e;
  logic [15:0] m_lfsr, m_misr, m_golden, m_pidx;
  exp_t        sb_q[$];
  bit          hist_scan [32];
  bit          hist_done [32];
  vec_t        tbl [12];

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? TAPS : 16'h0);
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] v, input logic [1:0] d);
    return {v[14:0], 1'b0} ^ (v[15] ? TAPS : 16'h0) ^ {14'h0, d};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_pass = 0; m_learned = 0; m_e = 0;
    m_lfsr = SEED; m_misr = 16'h0; m_golden = 16'h0; m_pidx = 16'h0;
  endtask

  // Model phase comes from the edge count since the start edge, not from a state machine.
  task automatic cycle(input bit b, output bit scan_pre, output bit done_post);
    exp_t        e;
    bit          exp_scan;
    logic [1:0]  exp_sdi;
    int          k;
    bistmode = b;
    #1;
    exp_scan = 0;
    exp_sdi  = 2'b00;
    if (m_run) begin
      k = m_e + 1;
      if (k <= NP * (L + 1)) begin
        if ((k - 1) % (L + 1) < L) begin
          exp_scan = 1;
          exp_sdi  = m_lfsr[1:0];
          if (b) begin
            if (m_pidx != 0) m_misr = misr_step(m_misr, sdo_l);
            m_lfsr = lfsr_step(m_lfsr);
          end
        end else if (b) begin
          m_pidx = m_pidx + 16'd1;
        end
      end else if (k <= NP * (L + 1) + L) begin
        exp_scan = 1;
        if (b) m_misr = misr_step(m_misr, sdo_l);
      end else if (b) begin
        if (!m_learned) begin
          m_golden = m_misr; m_learned = 1; m_pass = 1;
        end else begin
          m_pass = (m_misr == m_golden);
        end
        m_done = 1;
      end
      if (b && !m_done) m_e = k;
      else m_run = 0;
    end else if (m_done) begin
      if (!b) begin m_done = 0; m_pass = 0; end
    end else if (b) begin
      m_run = 1; m_e = 0; m_lfsr = SEED; m_misr = 16'h0; m_pidx = 16'h0;
    end
    chk("scanmode", bus_l.cut_scanmode, exp_scan);
    chk("cut_sdi", bus_l.cut_sdi, exp_sdi);
    scan_pre = bus_l.cut_scanmode;
    e.sig = m_misr; e.done = m_done; e.pass = m_done & m_pass; e.pidx = m_pidx;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("signature", bus_l.signature, e.sig);
    chk("bistdone", bus_l.bistdone, e.done);
    chk("bistpass", bus_l.bistpass, e.pass);
    chk("pattern_idx", bus_l.pattern_idx, e.pidx);
    chk("bistdone_f", bus_f.bistdone, e.done);
    done_post = bus_l.bistdone;
    @(negedge clk);
  endtask

  task automatic full_run(input string tag);
    bit s, d;
    for (int i = 0; i <= 20; i++) cycle(1, s, d);
    chk({tag, "_done"}, bus_l.bistdone, 1);
    chk({tag, "_pass_l"}, bus_l.bistpass, 1);
    chk({tag, "_pass_f"}, bus_f.bistpass, 0);
    chk({tag, "_sig_f_ne_golden"}, bus_f.signature != 16'h0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_scan_l"}, bus_l.cut_scanmode, 0);
    chk({tag, "_sdi_l"}, bus_l.cut_sdi, 0);
    chk({tag, "_done_l"}, bus_l.bistdone, 0);
    chk({tag, "_pass_l"}, bus_l.bistpass, 0);
    chk({tag, "_sig_l"}, bus_l.signature, 0);
    chk({tag, "_pidx_l"}, bus_l.pattern_idx, 0);
    chk({tag, "_golden_l"}, dut_l.golden_q, 16'h0000);
    chk({tag, "_learned_l"}, dut_l.learned_q, 0);
    chk({tag, "_scan_f"}, bus_f.cut_scanmode, 0);
    chk({tag, "_done_f"}, bus_f.bistdone, 0);
    chk({tag, "_sig_f"}, bus_f.signature, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          s, d;
    logic [15:0] sig1;
    tbl = '{'{1, 1, 0}, '{4, 1, 0}, '{5, 0, 0}, '{6, 1, 0}, '{10, 0, 0}, '{11, 1, 0},
            '{15, 0, 0}, '{16, 1, 0}, '{19, 1, 0}, '{20, 0, 1}, '{21, 0, 1}, '{22, 0, 1}};
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bistmode = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    cycle(0, s, d);

    // Run 1: latency and scanmode timeline, learn golden, hold bistmode through DONE.
    cycle(1, s, d);
    for (int e = 1; e <= 22; e++) begin
      cycle(1, s, d);
      hist_scan[e] = s;
      hist_done[e] = d;
    end
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("scan_edge%0d", tbl[i].edge_n), hist_scan[tbl[i].edge_n], tbl[i].scan);
      chk($sformatf("done_edge%0d", tbl[i].edge_n), hist_done[tbl[i].edge_n], tbl[i].done);
    end
    sig1 = m_misr;
    chk("run1_pass_l", bus_l.bistpass, 1);
    chk("run1_golden", dut_l.golden_q, sig1);
    chk("run1_pass_f", bus_f.bistpass, 0);
    chk("run1_sig_f_ne_golden", bus_f.signature != 16'h0, 1);
    cycle(0, s, d);
    chk("done_clear", bus_l.bistdone, 0);

    full_run("run2");
    chk("run2_sig", bus_l.signature, sig1);
    cycle(0, s, d);

    // Abort: bistmode low sampled at edge 8.
    cycle(1, s, d);
    for (int e = 1; e <= 7; e++) cycle(1, s, d);
    cycle(0, s, d);
    chk("abort_scan", bus_l.cut_scanmode, 0);
    chk("abort_done", bus_l.bistdone, 0);
    chk("abort_golden", dut_l.golden_q, sig1);
    cycle(0, s, d);
    full_run("post_abort");
    chk("post_abort_sig", bus_l.signature, sig1);
    cycle(0, s, d);

    // Reset asserted mid-UNLOAD.
    for (int e = 0; e <= 17; e++) cycle(1, s, d);
    chk("pre_reset_scan", bus_l.cut_scanmode, 1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle(0, s, d);
    full_run("relearn");
    cycle(0, s, d);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
